// File: rtl/hazard_if.sv
// Control bundle between the pipeline datapath and the hazard controller.
// The datapath side is the master; the controller is the slave.
interface hazard_if;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_rs_valid;
  logic        id_rt_valid;
  logic        id_halt;
  logic [2:0]  ex_rd;
  logic        ex_memRead;
  logic        ex_redirect;
  logic        imem_busy;
  logic        dmem_busy;

  logic        pc_we;
  logic        pc_redirect_sel;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_flush;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_rs_valid, id_rt_valid, id_halt,
           ex_rd, ex_memRead, ex_redirect, imem_busy, dmem_busy,
    input  pc_we, pc_redirect_sel, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, memwb_flush, halted, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_rs_valid, id_rt_valid, id_halt,
           ex_rd, ex_memRead, ex_redirect, imem_busy, dmem_busy,
    output pc_we, pc_redirect_sel, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, memwb_flush, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: Mealy enables and
// flushes for the pipeline registers, HALT drain and a front-end stall counter.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IDISCARD = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [15:0]    stall_q, stall_d;

  logic pc_we, pc_redirect_sel, ifid_we, idex_we, exmem_we;
  logic ifid_flush, idex_flush, memwb_flush;
  logic load_use;

  assign load_use = hz.ex_memRead &&
                    ((hz.id_rs_valid && (hz.id_rs == hz.ex_rd)) ||
                     (hz.id_rt_valid && (hz.id_rt == hz.ex_rd)));

  always_comb begin
    // NOTE: every output and next-state gets a default before any branch so no latch is inferred.
    state_d         = state_q;
    drain_d         = drain_q;
    pc_we           = 1'b1;
    pc_redirect_sel = 1'b0;
    ifid_we         = 1'b1;
    idex_we         = 1'b1;
    exmem_we        = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    memwb_flush     = 1'b0;

    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
      drain_d     = '0;
    end else begin
      unique case (state_q)
        RUN, IDISCARD: begin
          if (hz.dmem_busy) begin
            // Whole front and middle freeze; the bubble goes into MEM/WB.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
          end else if (hz.ex_redirect) begin
            pc_redirect_sel = 1'b1;
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
            state_d         = hz.imem_busy ? IDISCARD : RUN;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end else if (hz.imem_busy) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
          end else if (state_q == IDISCARD) begin
            // Word just returned belongs to the squashed address; refetch the target.
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            state_d    = RUN;
          end else if (hz.id_halt) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            state_d    = DRAIN;
            drain_d    = DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (hz.dmem_busy) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
          end else begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            drain_d    = drain_q - DW'(1);
            if (drain_q <= DW'(1)) state_d = HALTED;
          end
        end
        HALTED: begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          exmem_we = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end

    stall_d = stall_q;
    if ((state_q != HALTED) && !pc_we && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_we           = pc_we;
  assign hz.pc_redirect_sel = pc_redirect_sel;
  assign hz.ifid_we         = ifid_we;
  assign hz.idex_we         = idex_we;
  assign hz.exmem_we        = exmem_we;
  assign hz.ifid_flush      = ifid_flush;
  assign hz.idex_flush      = idex_flush;
  assign hz.memwb_flush     = memwb_flush;
  assign hz.halted          = (state_q == HALTED) && !rst;
  assign hz.stall_cycles    = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: control vectors checked mid-cycle, counter
// checked just after the clock edge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hazard_if hz ();

  hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // {pc_we, pc_redirect_sel, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush, halted}
  logic [8:0] outs;
  assign outs = {hz.pc_we, hz.pc_redirect_sel, hz.ifid_we, hz.idex_we, hz.exmem_we,
                 hz.ifid_flush, hz.idex_flush, hz.memwb_flush, hz.halted};

  localparam logic [8:0] O_RST    = 9'b0_0_000_111_0;
  localparam logic [8:0] O_RUN    = 9'b1_0_111_000_0;
  localparam logic [8:0] O_LU     = 9'b0_0_011_010_0;
  localparam logic [8:0] O_REDIR  = 9'b1_1_111_110_0;
  localparam logic [8:0] O_IFBUB  = 9'b0_0_111_100_0;
  localparam logic [8:0] O_FREEZE = 9'b0_0_000_001_0;
  localparam logic [8:0] O_HALTED = 9'b0_0_000_000_1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    hz.id_rs = 3'd0; hz.id_rt = 3'd0; hz.id_rs_valid = 1'b0; hz.id_rt_valid = 1'b0;
    hz.id_halt = 1'b0; hz.ex_rd = 3'd0; hz.ex_memRead = 1'b0; hz.ex_redirect = 1'b0;
    hz.imem_busy = 1'b0; hz.dmem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check(tag, {7'd0, outs}, {7'd0, exp});
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_outs("reset_outputs", O_RST);
    tick();
    check("reset_stall", hz.stall_cycles, 16'd0);
    rst = 1'b0;
    chk_outs("run_idle", O_RUN);
    tick();
    check("run_idle_stall", hz.stall_cycles, 16'd0);

    // Load-use on rs, then without rs_valid, then on rt.
    hz.ex_rd = 3'd3; hz.ex_memRead = 1'b1; hz.id_rs = 3'd3; hz.id_rs_valid = 1'b1;
    chk_outs("lu_rs", O_LU);
    tick();
    check("lu_rs_stall", hz.stall_cycles, 16'd1);
    hz.id_rs_valid = 1'b0;
    chk_outs("lu_rs_invalid", O_RUN);
    tick();
    check("lu_rs_invalid_stall", hz.stall_cycles, 16'd1);
    hz.id_rs = 3'd5; hz.id_rs_valid = 1'b1; hz.id_rt = 3'd3; hz.id_rt_valid = 1'b1;
    chk_outs("lu_rt", O_LU);
    tick();
    check("lu_rt_stall", hz.stall_cycles, 16'd2);
    idle_inputs();
    chk_outs("lu_released", O_RUN);
    tick();

    // Redirect during an outstanding fetch.
    hz.ex_redirect = 1'b1; hz.imem_busy = 1'b1;
    chk_outs("redir_fetch", O_REDIR);
    tick();
    check("redir_stall", hz.stall_cycles, 16'd2);
    hz.ex_redirect = 1'b0;
    chk_outs("idisc_busy1", O_IFBUB);
    tick();
    chk_outs("idisc_busy2", O_IFBUB);
    tick();
    hz.imem_busy = 1'b0;
    chk_outs("idisc_drop", O_IFBUB);
    tick();
    check("idisc_stall", hz.stall_cycles, 16'd5);
    chk_outs("idisc_back_run", O_RUN);
    tick();

    // dmem_busy freeze dominating redirect and load-use.
    hz.dmem_busy = 1'b1; hz.ex_redirect = 1'b1;
    hz.ex_rd = 3'd3; hz.ex_memRead = 1'b1; hz.id_rs = 3'd3; hz.id_rs_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_outs($sformatf("freeze_%0d", i), O_FREEZE);
      tick();
    end
    check("freeze_stall", hz.stall_cycles, 16'd9);
    hz.dmem_busy = 1'b0;
    chk_outs("freeze_redir", O_REDIR);
    tick();
    idle_inputs();
    chk_outs("post_redir_run", O_RUN);
    tick();
    check("post_redir_stall", hz.stall_cycles, 16'd9);

    // HALT drain; a redirect during drain must be ignored.
    hz.id_halt = 1'b1;
    chk_outs("halt_enter", O_IFBUB);
    tick();
    hz.id_halt = 1'b0; hz.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_outs($sformatf("drain_%0d", i), O_IFBUB);
      tick();
    end
    hz.ex_redirect = 1'b0;
    chk_outs("halted_state", O_HALTED);
    check("halted_stall", hz.stall_cycles, 16'd13);
    tick();
    check("halted_stall_hold", hz.stall_cycles, 16'd13);

    // Reset out of HALTED.
    rst = 1'b1;
    chk_outs("rst_in_halted", O_RST);
    tick();
    rst = 1'b0;
    chk_outs("after_rst_halted", O_RUN);
    check("after_rst_halted_stall", hz.stall_cycles, 16'd0);
    tick();

    // HALT with two dmem_busy cycles mid-drain: halted after the 6th edge.
    hz.id_halt = 1'b1;
    tick();
    hz.id_halt = 1'b0;
    tick();
    hz.dmem_busy = 1'b1;
    chk_outs("drain_freeze", O_FREEZE);
    tick();
    tick();
    hz.dmem_busy = 1'b0;
    tick();
    chk_outs("drain_last", O_IFBUB);
    tick();
    chk_outs("halted_after_freeze", O_HALTED);
    check("halt_freeze_stall", hz.stall_cycles, 16'd6);

    // Reset out of IDISCARD: no residual discard afterwards.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hz.ex_redirect = 1'b1; hz.imem_busy = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b1;
    chk_outs("rst_in_idiscard", O_RST);
    tick();
    rst = 1'b0;
    chk_outs("after_rst_idiscard", O_RUN);
    check("after_rst_idiscard_stall", hz.stall_cycles, 16'd0);
    tick();

    // Counter saturation.
    hz.imem_busy = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("stall_saturated", hz.stall_cycles, 16'hFFFF);
    tick();
    tick();
    check("stall_saturated_hold", hz.stall_cycles, 16'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage 16-bit core. It sits beside the pipeline registers and drives their write-enables and flushes, the PC write-enable and the PC redirect select. It resolves data-memory stalls, EX-stage branch/jump redirects (including a redirect that lands during an outstanding instruction fetch), load-use hazards, instruction-memory stalls and HALT drain. It also keeps a saturating front-end stall-cycle counter.

## Interface
Parameters:
- DRAIN_CYCLES, 3, number of unfrozen cycles after HALT leaves ID before `halted` asserts.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  3 each  source register numbers of the instruction in ID
- id_rs_valid, id_rt_valid  in  1 each  the ID instruction actually reads that source
- id_halt  in  1  the instruction in ID is HALT
- ex_rd  in  3  destination register of the instruction in EX
- ex_memRead  in  1  the instruction in EX is a load
- ex_redirect  in  1  EX resolved a taken branch or jump (updatedPC replaces next_PC_normal)
- imem_busy  in  1  instruction memory has not returned the word for the current PC
- dmem_busy  in  1  data memory access in MEM is not complete
- pc_we  out  1  PC register write enable
- pc_redirect_sel  out  1  PC mux selects the EX redirect target
- ifid_we, idex_we, exmem_we  out  1 each  pipeline register write enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a NOP into that register on the next edge
- halted  out  1  the core has retired HALT
- stall_cycles  out  16  count of front-end stall cycles

## Operation
- States: RUN, IDISCARD (a fetch is in flight for a squashed address), DRAIN (HALT moving to WB), HALTED. Reset state is RUN.
- Outputs are Mealy: they are a combinational function of the current state and inputs. Default: all `_we` = 1, all flushes = 0, pc_redirect_sel = 0.
- Priority in RUN and IDISCARD (first match wins):
  1. dmem_busy: pc_we = ifid_we = idex_we = exmem_we = 0 and memwb_flush = 1. State, drain count and pending discard all hold. Any concurrent redirect or load-use is deferred; its source is frozen and re-presents next cycle.
  2. ex_redirect: pc_we = 1, pc_redirect_sel = 1, ifid_flush = 1, idex_flush = 1. If imem_busy = 1, next state is IDISCARD; otherwise next state is RUN. id_halt is ignored because HALT is squashed.
  3. Load-use: ex_memRead && ((id_rs_valid && id_rs == ex_rd) || (id_rt_valid && id_rt == ex_rd)). Then pc_we = 0, ifid_we = 0, idex_flush = 1.
  4. imem_busy: pc_we = 0, ifid_flush = 1; the back end advances.
  5. IDISCARD with imem_busy = 0: the returned word is for the old address and is dropped. pc_we = 0, ifid_flush = 1, next state RUN, so the target is refetched.
  6. id_halt (RUN only): pc_we = 0, ifid_flush = 1, the HALT enters ID/EX, next state DRAIN, drain count loaded with DRAIN_CYCLES.
- DRAIN:
  - pc_we = 0, ifid_we = 1 with ifid_flush = 1; idex, exmem and memwb advance.
  - ex_redirect, id_halt and load-use are ignored.
  - dmem_busy freezes exactly as in rule 1 and the count holds.
  - Each unfrozen cycle decrements the count. The cycle that decrements it from 1 to 0 moves the state to HALTED.
- HALTED: all `_we` = 0, all flushes = 0, halted = 1. Leaves only on rst.
- stall_cycles: +1 on every cycle with rst = 0, state != HALTED and pc_we = 0. Saturates at 16'hFFFF with no wrap. Reset value 0.

## Timing
- While rst = 1: pc_we = 0, pc_redirect_sel = 0, all other `_we` = 0, ifid_flush = idex_flush = memwb_flush = 1, halted = 0. On the edge, state = RUN, drain count = 0, stall_cycles = 0.
- Mid-operation reset (including from DRAIN, IDISCARD or HALTED) returns to RUN on the next edge with no residual discard.
- Decisions take zero cycles. Enables and flushes act on the same edge as the triggering inputs.
- A load-use hazard costs exactly one bubble. A redirect costs two squashed slots, plus one more if IDISCARD is entered.
- Minimum ID-HALT to `halted`: DRAIN_CYCLES + 1 edges, plus one edge per dmem_busy cycle during DRAIN.

## Test plan
- Load-use: a load r3 in EX (ex_rd = 3, ex_memRead = 1) with id_rs = 3, id_rs_valid = 1 for one cycle. Required: pc_we = 0, ifid_we = 0, idex_flush = 1 that cycle only; stall_cycles goes 0 → 1. The same case with id_rs_valid = 0 gives no stall.
- Redirect during fetch: ex_redirect = 1, imem_busy = 1. Required: pc_redirect_sel = 1, pc_we = 1, ifid_flush = idex_flush = 1, state → IDISCARD. Then imem_busy is 1 for 2 cycles and then 0. Required: the ifid_flush = 1, pc_we = 0 discard cycle, then RUN with all enables = 1.
- dmem_busy for 4 cycles while ex_redirect = 1 and a load-use hazard are both present. Required: a full freeze with memwb_flush = 1 for 4 cycles, and the redirect taken on cycle 5.
- HALT: id_halt = 1 in RUN. Required: DRAIN for 3 cycles, halted = 1 on the 4th edge. Repeat with dmem_busy = 1 for 2 cycles mid-drain: halted = 1 on the 6th edge.
- Reset asserted in HALTED and in IDISCARD. Required: the reset output values during rst, RUN afterwards, stall_cycles = 0 and halted = 0.
- Saturation: hold imem_busy = 1 for 65,540 cycles. Required: stall_cycles = 16'hFFFF and it stays there.
